// File: rtl/data_mem_responder_if.sv
// Data-memory port between the pipeline core and the memory responder.
// The core drives the request (address, write data, write strobe) and
// receives the registered read data one cycle later.
interface data_mem_responder_if #(
  parameter int AW = 9,
  parameter int DW = 16
);

  logic [AW-1:0] addr_mem;
  logic [DW-1:0] wdata_mem;
  logic          write_mem;
  logic [DW-1:0] rdata;

  // Core side: issues requests, consumes read data
  modport master (
    output addr_mem,
    output wdata_mem,
    output write_mem,
    input  rdata
  );

  // Memory side: services requests, returns read data
  modport slave (
    input  addr_mem,
    input  wdata_mem,
    input  write_mem,
    output rdata
  );

endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with write-first registered reads, a
// power-up clear sequence that zeroes every word before service starts,
// and two memory-mapped I/O words (LED register, synchronized switches).
module data_mem_responder #(
  parameter int            AW       = 9,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] LED_ADDR = 9'h1FF,
  parameter logic [AW-1:0] SW_ADDR  = 9'h1FE
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus,
  input  logic [7:0]            switches_in,
  output logic [7:0]            leds_out,
  output logic                  busy,
  output logic                  ro_err
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t        state_q,  state_d;
  logic [AW-1:0] clrIdx_q, clrIdx_d;
  logic [DW-1:0] rdata_q,  rdata_d;
  logic [7:0]    leds_q,   leds_d;
  logic          roErr_q,  roErr_d;
  logic [7:0]    swMeta_q;
  logic [7:0]    swSync_q;

  logic [DW-1:0] mem [DEPTH];

  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [DW-1:0] memWdata;
  logic          isLed;
  logic          isSw;

  // Two-flop synchronizer bringing the asynchronous board switches into clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swMeta_q <= '0;
      swSync_q <= '0;
    end else begin
      swMeta_q <= switches_in;
      swSync_q <= swMeta_q;
    end
  end

  // State, clear counter and the registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= CLEAR;
      clrIdx_q <= '0;
      rdata_q  <= '0;
      leds_q   <= '0;
      roErr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
      rdata_q  <= rdata_d;
      leds_q   <= leds_d;
      roErr_q  <= roErr_d;
    end
  end

  // RAM write port; contents are not reset, the CLEAR sequence zeroes them
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  // Next-state, RAM write control and write-first read data selection
  always_comb begin
    state_d  = state_q;
    clrIdx_d = clrIdx_q;
    rdata_d  = '0;
    leds_d   = leds_q;
    roErr_d  = roErr_q;
    memWe    = 1'b0;
    memWaddr = clrIdx_q;
    memWdata = '0;
    isLed    = (bus.addr_mem == LED_ADDR);
    isSw     = (bus.addr_mem == SW_ADDR);

    unique case (state_q)
      CLEAR: begin
        memWe    = 1'b1;
        memWaddr = clrIdx_q;
        memWdata = '0;
        clrIdx_d = clrIdx_q + AW'(1);
        if (clrIdx_q == LAST_IDX) begin
          state_d = READY;
        end
      end

      READY: begin
        if (isLed) begin
          if (bus.write_mem) begin
            leds_d = bus.wdata_mem[7:0];
          end
          rdata_d = {{(DW-8){1'b0}}, leds_d};
        end else if (isSw) begin
          if (bus.write_mem) begin
            roErr_d = 1'b1;
          end
          rdata_d = {{(DW-8){1'b0}}, swSync_q};
        end else begin
          memWe    = bus.write_mem;
          memWaddr = bus.addr_mem;
          memWdata = bus.wdata_mem;
          rdata_d  = bus.write_mem ? bus.wdata_mem : mem[bus.addr_mem];
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign bus.rdata = rdata_q;
  assign leds_out  = leds_q;
  assign ro_err    = roErr_q;
  assign busy      = (state_q == CLEAR);

endmodule
